// File: rtl/mc_control_fsm.sv
// rtl/mc_control_fsm.sv - multicycle MIPS main control FSM with ALU-control decode
module mc_control_fsm (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       Zero,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       PCEn,
  output logic [1:0] PCSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic       RFDSel,
  output logic       MemtoReg,
  output logic       RFWE,
  output logic       Illegal
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [3:0] S_RESET   = 4'd0;
  localparam logic [3:0] S_FETCH   = 4'd1;
  localparam logic [3:0] S_DECODE  = 4'd2;
  localparam logic [3:0] S_MEMADR  = 4'd3;
  localparam logic [3:0] S_MEMRD   = 4'd4;
  localparam logic [3:0] S_MEMWB   = 4'd5;
  localparam logic [3:0] S_MEMWR   = 4'd6;
  localparam logic [3:0] S_EXECUTE = 4'd7;
  localparam logic [3:0] S_ALUWB   = 4'd8;
  localparam logic [3:0] S_BRANCH  = 4'd9;
  localparam logic [3:0] S_ADDIEX  = 4'd10;
  localparam logic [3:0] S_ADDIWB  = 4'd11;
  localparam logic [3:0] S_JUMP    = 4'd12;

  logic [3:0] state;
  logic [3:0] next_state;
  logic       is_store;
  logic       pc_write;
  logic       branch;

  // State register; reset forces RESET without waiting for a clock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_RESET;
    else        state <= next_state;
  end

  // Remember load vs store in DECODE so MEMADR does not look at Op again
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  is_store <= 1'b0;
    else if (state == S_DECODE)  is_store <= (Op == OP_SW);
  end

  // Next-state decode; unused encodings fall back to FETCH
  always_comb begin
    next_state = S_FETCH;
    case (state)
      S_RESET:   next_state = S_FETCH;
      S_FETCH:   next_state = S_DECODE;
      S_DECODE: begin
        case (Op)
          OP_LW, OP_SW: next_state = S_MEMADR;
          OP_RTYPE:     next_state = S_EXECUTE;
          OP_BEQ:       next_state = S_BRANCH;
          OP_ADDI:      next_state = S_ADDIEX;
          OP_J:         next_state = S_JUMP;
          default:      next_state = S_FETCH;
        endcase
      end
      S_MEMADR:  next_state = is_store ? S_MEMWR : S_MEMRD;
      S_MEMRD:   next_state = S_MEMWB;
      S_EXECUTE: next_state = S_ALUWB;
      S_ADDIEX:  next_state = S_ADDIWB;
      default:   next_state = S_FETCH;
    endcase
  end

  // Moore output decode; only ALUControl in EXECUTE and Illegal in DECODE look at inputs
  always_comb begin
    IorD       = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    PCSrc      = 2'b00;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUControl = ALU_ADD;
    RFDSel     = 1'b0;
    MemtoReg   = 1'b0;
    RFWE       = 1'b0;
    Illegal    = 1'b0;
    pc_write   = 1'b0;
    branch     = 1'b0;
    case (state)
      S_FETCH: begin
        IRWrite  = 1'b1;
        ALUSrcB  = 2'b01;
        pc_write = 1'b1;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        case (Op)
          OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: Illegal = 1'b0;
          default:                                       Illegal = 1'b1;
        endcase
      end
      S_MEMADR, S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMRD: IorD = 1'b1;
      S_MEMWB: begin
        MemtoReg = 1'b1;
        RFWE     = 1'b1;
      end
      S_MEMWR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXECUTE: begin
        ALUSrcA = 1'b1;
        case (Funct)
          6'b100010: ALUControl = ALU_SUB;
          6'b100100: ALUControl = ALU_AND;
          6'b100101: ALUControl = ALU_OR;
          6'b101010: ALUControl = ALU_SLT;
          default:   ALUControl = ALU_ADD;
        endcase
      end
      S_ALUWB: begin
        RFDSel = 1'b1;
        RFWE   = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUControl = ALU_SUB;
        PCSrc      = 2'b01;
        branch     = 1'b1;
      end
      S_ADDIWB: RFWE = 1'b1;
      S_JUMP: begin
        PCSrc    = 2'b10;
        pc_write = 1'b1;
      end
      default: ;
    endcase
  end

  assign PCEn = pc_write | (branch & Zero);

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Multicycle MIPS main control unit: a Moore state machine sequencing fetch, decode, execute, memory and writeback, plus a combinational ALU-control decoder.
- Sits directly upstream of the datapath muxes and drives RFDSel (register-file write-address select rt/rd), MemtoReg, RFWE, the PC/IR enables and the ALU selects.
- Consumes opcode/funct from the instruction register and Zero from the ALU.

Parameters:
OP_RTYPE, 6'b000000, R-type opcode
OP_LW, 6'b100011, load word
OP_SW, 6'b101011, store word
OP_BEQ, 6'b000100, branch if equal
OP_ADDI, 6'b001000, add immediate
OP_J, 6'b000010, jump

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
Op  input  6  instr[31:26] from IR
Funct  input  6  instr[5:0] from IR
Zero  input  1  ALU zero flag
IorD  output  1  memory address: 0=PC, 1=ALUOut
MemWrite  output  1  data memory write enable
IRWrite  output  1  instruction register load
PCEn  output  1  PCWrite | (Branch & Zero)
PCSrc  output  2  00=ALUResult, 01=ALUOut, 10=jump target
ALUSrcA  output  1  0=PC, 1=A register
ALUSrcB  output  2  00=B, 01=const 4, 10=SignImm, 11=SignImm<<2
ALUControl  output  3  010 add, 110 sub, 000 and, 001 or, 111 slt
RFDSel  output  1  register write address: 0=rt, 1=rd
MemtoReg  output  1  register write data: 0=ALUOut, 1=MDR
RFWE  output  1  register file write enable
Illegal  output  1  one-cycle pulse in DECODE for an unknown opcode

Behaviour:
- State register updates on posedge clk. rst_n=0 forces RESET asynchronously.
- Outputs decode combinationally from state only (Moore), except PCEn (uses Zero) and ALUControl (uses Funct in ALUWB-path execute).
- RESET: all outputs 0; RFDSel=0; ALUControl=010. Goes to FETCH on the first clock edge after rst_n rises.
- FETCH: IorD=0, IRWrite=1, ALUSrcA=0, ALUSrcB=01, ALUControl=010, PCSrc=00, PCWrite=1 -> DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, add (branch target into ALUOut). Next state by Op:
  - LW/SW -> MEMADR
  - RTYPE -> EXECUTE
  - BEQ -> BRANCH
  - ADDI -> ADDIEX
  - J -> JUMP
  - anything else -> FETCH with Illegal=1 for this cycle
- MEMADR: ALUSrcA=1, ALUSrcB=10, add. LW -> MEMRD, SW -> MEMWR.
- MEMRD: IorD=1 -> MEMWB.
- MEMWB: RFDSel=0, MemtoReg=1, RFWE=1 -> FETCH.
- MEMWR: IorD=1, MemWrite=1 -> FETCH.
- EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUControl from Funct:
  - 100000 -> 010; 100010 -> 110; 100100 -> 000; 100101 -> 001; 101010 -> 111
  - unknown funct -> 010, no flag
  - next -> ALUWB
- ALUWB: RFDSel=1, MemtoReg=0, RFWE=1 -> FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, sub, PCSrc=01, Branch=1; PCEn=Zero -> FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, add -> ADDIWB.
- ADDIWB: RFDSel=0, MemtoReg=0, RFWE=1 -> FETCH.
- JUMP: PCSrc=10, PCWrite=1 -> FETCH.
- Unlisted outputs in any state: 0 (ALUControl 010).
- Cycles per instruction, FETCH to next FETCH: lw 5, sw 4, R 4, addi 4, beq 3, j 3.
- Op and Funct are sampled only in DECODE/EXECUTE. Mid-instruction changes have no effect elsewhere.
- Unused state encodings recover to FETCH on the next edge.
- Reset asserted in any state: outputs drop to RESET values immediately, without waiting for a clock; RFWE and MemWrite are never left asserted.

Test Plan:
- Reset release, Op=LW -> RESET, FETCH(IRWrite=1, PCEn=1), DECODE, MEMADR, MEMRD(IorD=1), MEMWB(RFWE=1, MemtoReg=1, RFDSel=0), then FETCH; 5 cycles.
- Op=RTYPE, Funct=100010 -> EXECUTE ALUControl=110; ALUWB RFDSel=1, RFWE=1; back to FETCH after 4 cycles.
- Op=BEQ, Zero=1 -> BRANCH PCEn=1, PCSrc=01. Repeat with Zero=0 -> PCEn=0. Both return to FETCH after 3 cycles.
- Op=SW -> MEMWR MemWrite=1, IorD=1, RFWE=0 throughout. Op=J -> JUMP PCSrc=10, PCEn=1.
- Op=6'b111111 -> Illegal=1 for one cycle in DECODE, next state FETCH, no RFWE/MemWrite pulse.
- rst_n pulled low mid-MEMWB -> RFWE=0 and state RESET without a clock edge. After release, FETCH on the next edge.
